// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multicycle controller.
//   state_t    - FSM state encoding (also visible on the State debug port)
//   ctrl_t     - per-state, ungated control vector
//   ALU_*      - ALUControl encodings
//   OP_*       - instruction class encodings (Instr[27:26])
//   COND_*     - ARM condition-code field encodings (Instr[31:28])
//   state_ctrl - maps a state to its ungated control vector
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP     = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Ungated controls; reg_w, mem_w and branch are qualified by the
  // latched condition result before they reach the datapath.
  typedef struct packed {
    logic       ir_write;
    logic       pc_fetch;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_fetch   = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      MEMADR:   c.alu_src_b = 2'b01;
      MEMRD:    c.adr_src = 1'b1;
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_w      = 1'b1;
      end
      MEMWR: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      EXECUTER: begin
        c.alu_src_b = 2'b00;
        c.alu_op    = 1'b1;
      end
      EXECUTEI: begin
        c.alu_src_b = 2'b01;
        c.alu_op    = 1'b1;
      end
      ALUWB:    c.reg_w = 1'b1;
      BRANCH: begin
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        c.branch     = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_condlogic.sv
// mc_condlogic: condition flags, condition evaluation and write gating.
//   clk, reset   - clock, asynchronous active-high reset
//   cond         - instruction condition field
//   alu_flags    - {N,Z,C,V} produced by the ALU this cycle
//   latch_cond   - high in DECODE; captures the condition result
//   alu_op       - high in the execute states
//   set_flags    - S bit of the instruction (funct[0])
//   alu_control  - current ALU operation, restricts C/V updates
//   reg_w, mem_w, branch, pc_fetch, rd_is_pc - ungated controls
//   reg_write, mem_write, pc_write - gated write enables
module mc_condlogic
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       latch_cond,
  input  logic       alu_op,
  input  logic       set_flags,
  input  logic [1:0] alu_control,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       branch,
  input  logic       pc_fetch,
  input  logic       rd_is_pc,
  output logic       reg_write,
  output logic       mem_write,
  output logic       pc_write
);

  logic [3:0] flags_q, flags_d;
  logic       condexr_q, condexr_d;
  logic       cond_ex;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  // Condition evaluation against the stored flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

  // The condition result is frozen when leaving DECODE so that later flag
  // writes by this same instruction cannot change its own gating.
  // Logical ops leave C and V alone, only ADD/SUB produce them.
  always_comb begin
    flags_d   = flags_q;
    condexr_d = condexr_q;
    if (latch_cond) begin
      condexr_d = cond_ex;
    end
    if (alu_op && set_flags && condexr_q) begin
      flags_d[3:2] = alu_flags[3:2];
      if (alu_control == ALU_ADD || alu_control == ALU_SUB) begin
        flags_d[1:0] = alu_flags[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      condexr_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      condexr_q <= condexr_d;
    end
  end

  // FETCH increments the PC unconditionally; other PC writes are branches
  // or register writebacks that target R15.
  assign reg_write = reg_w & condexr_q;
  assign mem_write = mem_w & condexr_q;
  assign pc_write  = pc_fetch | ((branch | (reg_w & rd_is_pc)) & condexr_q);

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM and instruction decoders for the
// multicycle ARM-subset core.
//   clk, reset  - clock, asynchronous active-high reset
//   Instr       - instruction bits [31:12] (cond, op, funct, Rd)
//   ALUFlags    - {N,Z,C,V} from the ALU
//   PCWrite, MemWrite, RegWrite, IRWrite - write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc  - datapath mux selects
//   ImmSrc, RegSrc, ALUControl            - decoded from the instruction
//   State       - current FSM state for debug
module multicycle_controller
  import mc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         IRWrite,
  output logic         AdrSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ALUControl,
  output logic [3:0]   State
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_instr;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  // Rn is decoded by the datapath, not the controller.
  assign unused_instr = ^Instr[19:16];

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  // Next-state logic; the control vector is precomputed for the next
  // state so every control output comes straight from a flop.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_DP:     state_d = funct[5] ? EXECUTEI : EXECUTER;
          OP_MEM:    state_d = MEMADR;
          OP_BRANCH: state_d = BRANCH;
          default:   state_d = FETCH;
        endcase
      end
      MEMADR:             state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:              state_d = MEMWB;
      EXECUTER, EXECUTEI: state_d = ALUWB;
      default:            state_d = FETCH;
    endcase
    ctrl_d = state_ctrl(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= state_ctrl(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Immediate and register-source selection depend only on the class.
  always_comb begin
    ImmSrc = 2'b00;
    RegSrc = 2'b00;
    case (op)
      OP_MEM: begin
        ImmSrc = 2'b01;
        RegSrc = {~funct[0], 1'b0};
      end
      OP_BRANCH: begin
        ImmSrc = 2'b10;
        RegSrc = 2'b01;
      end
      default: ;
    endcase
  end

  // Outside the execute states the ALU is used only for address/PC adds.
  always_comb begin
    ALUControl = ALU_ADD;
    if (ctrl_q.alu_op) begin
      case (funct[4:1])
        4'b0100: ALUControl = ALU_ADD;
        4'b0010: ALUControl = ALU_SUB;
        4'b0000: ALUControl = ALU_AND;
        4'b1100: ALUControl = ALU_ORR;
        default: ALUControl = ALU_ADD;
      endcase
    end
  end

  logic latch_cond;
  logic rd_is_pc;

  assign latch_cond = (state_q == DECODE);
  assign rd_is_pc   = (rd == 4'hF);

  mc_condlogic u_condlogic (
    .clk         (clk),
    .reset       (reset),
    .cond        (cond),
    .alu_flags   (ALUFlags),
    .latch_cond  (latch_cond),
    .alu_op      (ctrl_q.alu_op),
    .set_flags   (funct[0]),
    .alu_control (ALUControl),
    .reg_w       (ctrl_q.reg_w),
    .mem_w       (ctrl_q.mem_w),
    .branch      (ctrl_q.branch),
    .pc_fetch    (ctrl_q.pc_fetch),
    .rd_is_pc    (rd_is_pc),
    .reg_write   (RegWrite),
    .mem_write   (MemWrite),
    .pc_write    (PCWrite)
  );

  assign IRWrite   = ctrl_q.ir_write;
  assign AdrSrc    = ctrl_q.adr_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ResultSrc = ctrl_q.result_src;
  assign State     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller.
// Each instruction is described by hand: its state sequence, whether its
// condition passes given the flags left by earlier instructions, and the
// expected ALUControl/ImmSrc/RegSrc. Expected per-cycle vectors are queued
// by the stimulus process and popped by a monitor on every falling edge.
module tb_multicycle_controller;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:12] instr = 20'h00000;
  logic [3:0]   alu_flags = 4'b0000;
  logic         pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a;
  logic [1:0]   alu_src_b, result_src, imm_src, reg_src, alu_control;
  logic [3:0]   state;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (instr),
    .ALUFlags   (alu_flags),
    .PCWrite    (pc_write),
    .MemWrite   (mem_write),
    .RegWrite   (reg_write),
    .IRWrite    (ir_write),
    .AdrSrc     (adr_src),
    .ALUSrcA    (alu_src_a),
    .ALUSrcB    (alu_src_b),
    .ResultSrc  (result_src),
    .ImmSrc     (imm_src),
    .RegSrc     (reg_src),
    .ALUControl (alu_control),
    .State      (state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       irw;
    logic       pcw;
    logic       regw;
    logic       memw;
    logic       adr;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] rsrc;
    logic [1:0] imm;
    logic [1:0] rgs;
    logic [1:0] aluc;
  } obs_t;

  obs_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cycle_no = 0;

  // Ungated per-state outputs, written out from the state table.
  function automatic obs_t base_vec(input logic [3:0] s);
    obs_t e;
    e = '0;
    e.st = s;
    case (s)
      4'd0: begin e.irw = 1'b1; e.pcw = 1'b1; e.asa = 1'b1; e.asb = 2'b10; e.rsrc = 2'b10; end
      4'd1: begin e.asa = 1'b1; e.asb = 2'b10; e.rsrc = 2'b10; end
      4'd2: e.asb = 2'b01;
      4'd3: e.adr = 1'b1;
      4'd4: e.rsrc = 2'b01;
      4'd5: e.adr = 1'b1;
      4'd6: e.asb = 2'b00;
      4'd7: e.asb = 2'b01;
      4'd9: begin e.asb = 2'b01; e.rsrc = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input obs_t e, input obs_t a);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("[TB] FAIL ctrl cycle %0d: got state=%0d vec=%h, required state=%0d vec=%h",
               cycle_no, a.st, a, e.st, e);
    end
  endtask

  // seq holds the expected states as hex nibbles, first state leftmost.
  task automatic applyStimulus(input logic [19:0] i, input logic [3:0] f,
                               input logic [23:0] seq, input int len, input int run,
                               input bit ok, input logic [1:0] aluc,
                               input logic [1:0] imm, input logic [1:0] rgs);
    obs_t       e;
    logic [3:0] s;
    logic [3:0] rd;
    instr     = i;
    alu_flags = f;
    rd        = i[3:0];
    for (int k = 0; k < run; k++) begin
      s = seq[4*(len-1-k) +: 4];
      e = base_vec(s);
      e.imm = imm;
      e.rgs = rgs;
      if (s == 4'd6 || s == 4'd7) e.aluc = aluc;
      if (ok) begin
        if (s == 4'd4 || s == 4'd8) e.regw = 1'b1;
        if (s == 4'd5) e.memw = 1'b1;
        if (s == 4'd9) e.pcw = 1'b1;
        if ((s == 4'd4 || s == 4'd8) && rd == 4'hF) e.pcw = 1'b1;
      end
      exp_q.push_back(e);
    end
    repeat (run) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{st: state, irw: ir_write, pcw: pc_write, regw: reg_write, memw: mem_write,
            adr: adr_src, asa: alu_src_a, asb: alu_src_b, rsrc: result_src,
            imm: imm_src, rgs: reg_src, aluc: alu_control};
      checkOutput(e, a);
      cycle_no++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Held in reset: FETCH vector.
    @(posedge clk);
    #1;
    repeat (2) exp_q.push_back(base_vec(4'd0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    //            instr     flags  seq        len run ok aluc   imm    regsrc
    applyStimulus(20'hE2802, 4'b0000, 24'h0178, 4, 4, 1, 2'b00, 2'b00, 2'b00); // ADD
    applyStimulus(20'hE2537, 4'b0100, 24'h0178, 4, 4, 1, 2'b01, 2'b00, 2'b00); // SUBS -> Z
    applyStimulus(20'h0A000, 4'b0000, 24'h019,  3, 3, 1, 2'b00, 2'b10, 2'b01); // BEQ taken
    applyStimulus(20'h1A000, 4'b0000, 24'h019,  3, 3, 0, 2'b00, 2'b10, 2'b01); // BNE not taken
    applyStimulus(20'h0A000, 4'b0000, 24'h019,  3, 3, 1, 2'b00, 2'b10, 2'b01); // Z kept
    applyStimulus(20'h12537, 4'b0000, 24'h0178, 4, 4, 0, 2'b01, 2'b00, 2'b00); // SUBSNE fails
    applyStimulus(20'h0A000, 4'b0000, 24'h019,  3, 3, 1, 2'b00, 2'b10, 2'b01); // Z still kept
    applyStimulus(20'hE5902, 4'b0000, 24'h01234,5, 5, 1, 2'b00, 2'b01, 2'b00); // LDR
    applyStimulus(20'hE5802, 4'b0000, 24'h0125, 4, 4, 1, 2'b00, 2'b01, 2'b10); // STR
    applyStimulus(20'hEC000, 4'b0000, 24'h01,   2, 2, 1, 2'b00, 2'b00, 2'b00); // op=11
    applyStimulus(20'hE2902, 4'b0010, 24'h0178, 4, 4, 1, 2'b00, 2'b00, 2'b00); // ADDS -> C
    applyStimulus(20'hE2102, 4'b0000, 24'h0178, 4, 4, 1, 2'b10, 2'b00, 2'b00); // ANDS keeps C
    applyStimulus(20'h2A000, 4'b0000, 24'h019,  3, 3, 1, 2'b00, 2'b10, 2'b01); // BCS taken
    applyStimulus(20'hE3802, 4'b0100, 24'h0178, 4, 4, 1, 2'b11, 2'b00, 2'b00); // ORR, no S
    applyStimulus(20'hE2202, 4'b0100, 24'h0178, 4, 4, 1, 2'b00, 2'b00, 2'b00); // other funct
    applyStimulus(20'hE280F, 4'b0000, 24'h0178, 4, 4, 1, 2'b00, 2'b00, 2'b00); // ADD to PC
    applyStimulus(20'hE0802, 4'b0000, 24'h0168, 4, 4, 1, 2'b00, 2'b00, 2'b00); // ADD register
    applyStimulus(20'h0A000, 4'b0000, 24'h019,  3, 3, 0, 2'b00, 2'b10, 2'b01); // BEQ, Z=0
    applyStimulus(20'hF2802, 4'b0000, 24'h0178, 4, 4, 0, 2'b00, 2'b00, 2'b00); // cond=1111

    // LDR aborted by reset while in MEMRD.
    applyStimulus(20'hE5902, 4'b0000, 24'h01234,5, 3, 1, 2'b00, 2'b01, 2'b00);
    #1;
    reset = 1'b1;
    begin
      obs_t e;
      e = base_vec(4'd0);
      e.imm = 2'b01;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    // Flags were cleared by reset, so BEQ must not be taken.
    applyStimulus(20'h0A000, 4'b0000, 24'h019,  3, 3, 0, 2'b00, 2'b10, 2'b01);
    applyStimulus(20'hE2802, 4'b0000, 24'h0178, 4, 4, 1, 2'b00, 2'b00, 2'b00);

    @(negedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
